// File: rtl/carcontrol_oci_dct_pkg.sv
// rtl/carcontrol_oci_dct_pkg.sv - shared widths, frame typedef and packer states for the OCI DCT packer
package carcontrol_oci_dct_pkg;

    localparam int ATOM_W  = 2;
    localparam int DEPTH   = 15;
    localparam int CNT_W   = 4;
    localparam int BUF_W   = ATOM_W * DEPTH;
    localparam int FRAME_W = CNT_W + BUF_W;

    // Frame layout as seen on frame_data: fill count above the packed atoms
    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [BUF_W-1:0] buffer;
    } dct_frame_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_HELD    = 2'd2
    } dct_state_t;

endpackage

// File: rtl/carcontrol_oci_dct_frame_reg.sv
// rtl/carcontrol_oci_dct_frame_reg.sv - one-entry valid/ready holding register for closed DCT frames
module carcontrol_oci_dct_frame_reg
    import carcontrol_oci_dct_pkg::*;
#(
    parameter int W = FRAME_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         frame_ready,
    output logic         frame_valid,
    output logic [W-1:0] frame_data,
    output logic         free
);

    // Free also when the current frame drains this cycle, so a load can replace it without a bubble
    assign free = !frame_valid || frame_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
        end else if (load) begin
            frame_valid <= 1'b1;
            frame_data  <= load_data;
        end else if (frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/carcontrol_nios2_oci_dct_packer.sv
// rtl/carcontrol_nios2_oci_dct_packer.sv - packs 2-bit trace atoms into 15-atom DCT frames for the trace sink
module carcontrol_nios2_oci_dct_packer
    import carcontrol_oci_dct_pkg::*;
#(
    parameter int ATOM_W = carcontrol_oci_dct_pkg::ATOM_W,
    parameter int DEPTH  = carcontrol_oci_dct_pkg::DEPTH,
    parameter int CNT_W  = carcontrol_oci_dct_pkg::CNT_W
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            atom_valid,
    input  logic [ATOM_W-1:0]               atom,
    input  logic                            flush,
    input  logic                            frame_ready,
    output logic                            frame_valid,
    output logic [CNT_W+ATOM_W*DEPTH-1:0]   frame_data,
    output logic [ATOM_W*DEPTH-1:0]         dct_buffer,
    output logic [CNT_W-1:0]                dct_count,
    output logic                            overflow,
    output logic [7:0]                      drop_count
);

    localparam int BW = ATOM_W * DEPTH;

    dct_state_t        state_q, state_d;
    logic [BW-1:0]     buf_q, app_buf;
    logic [CNT_W-1:0]  cnt_q, app_cnt;
    logic              close, free, accept, drop, load;

    // Buffer contents after this cycle's atom; in HELD nothing is appended so this is the held frame
    always_comb begin
        app_buf = buf_q;
        app_cnt = cnt_q;
        if (atom_valid && state_q != ST_HELD) begin
            app_buf = {buf_q[BW-ATOM_W-1:0], atom};
            app_cnt = cnt_q + CNT_W'(1);
        end
        close = (state_q == ST_HELD) || (app_cnt == CNT_W'(DEPTH)) ||
                (flush && app_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (close)               state_d = free ? ST_EMPTY : ST_HELD;
        else if (app_cnt != '0)  state_d = ST_FILLING;
        else                     state_d = ST_EMPTY;
    end

    always_comb begin
        accept = 1'b0;
        drop   = 1'b0;
        load   = 1'b0;
        case (state_q)
            ST_HELD: begin
                drop = atom_valid;
                load = free;
            end
            default: begin
                accept = atom_valid;
                load   = close && free;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q      <= '0;
            cnt_q      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (load) begin
                buf_q <= '0;
                cnt_q <= '0;
            end else if (accept) begin
                buf_q <= app_buf;
                cnt_q <= app_cnt;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

    carcontrol_oci_dct_frame_reg #(.W(CNT_W + BW)) u_frame_reg (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .load_data   ({app_cnt, app_buf}),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .free        (free)
    );

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;

endmodule

// File: tb/tb_carcontrol_nios2_oci_dct_packer.sv
// tb/tb_carcontrol_nios2_oci_dct_packer.sv - scoreboard bench for the OCI DCT packer
module tb_carcontrol_nios2_oci_dct_packer;
    import carcontrol_oci_dct_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, atom_valid, flush, frame_ready;
    logic [1:0]  atom;
    logic        frame_valid, overflow;
    logic [33:0] frame_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    carcontrol_nios2_oci_dct_packer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .atom_valid  (atom_valid),
        .atom        (atom),
        .flush       (flush),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    int         checks = 0;
    int         failures = 0;
    int         n_frames = 0;
    dct_frame_t exp_q[$];
    int         cur[$];
    bit         m_held, m_fv, m_ovf;
    int         m_drops;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [29:0] pack_cur();
        logic [29:0] v = '0;
        foreach (cur[i]) v = v * 30'd4 + 30'(cur[i]);
        return v;
    endfunction

    task automatic emit_frame();
        dct_frame_t f;
        f.count  = 4'(cur.size());
        f.buffer = pack_cur();
        exp_q.push_back(f);
        cur.delete();
    endtask

    // Reference: an atom list, a "closed but waiting" flag and the sink-side occupancy
    task automatic model_step(input bit av, input logic [1:0] a, input bit fl, input bit rdy, input bit rst);
        bit free, loaded;
        if (!rst) begin
            cur.delete(); exp_q.delete();
            m_held = 0; m_fv = 0; m_ovf = 0; m_drops = 0;
            return;
        end
        free   = !m_fv || rdy;
        loaded = 0;
        if (m_held) begin
            if (av) begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
            if (free) begin
                emit_frame(); m_held = 0; loaded = 1;
            end
        end else begin
            if (av) cur.push_back(int'(a));
            if (cur.size() == 15 || (fl && cur.size() > 0)) begin
                if (free) begin
                    emit_frame(); loaded = 1;
                end else begin
                    m_held = 1;
                end
            end
        end
        if (loaded) m_fv = 1;
        else if (rdy) m_fv = 0;
    endtask

    task automatic step(input bit av, input logic [1:0] a, input bit fl, input bit rdy, input bit rst = 1'b1);
        atom_valid = av; atom = a; flush = fl; frame_ready = rdy; reset_n = rst;
        model_step(av, a, fl, rdy, rst);
        @(posedge clk); #1;
        chk("dct_count", dct_count, cur.size());
        chk("dct_buffer", dct_buffer, pack_cur());
        chk("frame_valid", frame_valid, m_fv);
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drops);
    endtask

    task automatic drain(input string name);
        int budget = 40;
        while (exp_q.size() != 0 && budget > 0) begin
            step(0, 2'd0, 0, 1);
            budget--;
        end
        step(0, 2'd0, 0, 1);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        atom_valid = 0; atom = 0; flush = 0; frame_ready = 0; reset_n = 0;

        fork
            forever begin
                @(negedge clk);
                if (reset_n && frame_valid && frame_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL frame_unexpected actual=%0h required=none", frame_data);
                    end else begin
                        chk("frame_data", frame_data, exp_q.pop_front());
                        n_frames++;
                    end
                end
            end
        join_none

        step(0, 2'd0, 0, 0, 0);
        step(0, 2'd0, 0, 0, 0);
        chk("reset_frame_data", frame_data, 0);

        // Full frame 1,2,3,0,...
        for (int i = 0; i < 15; i++) step(1, seq[i % 4], 0, 1);
        chk("full_frame", frame_data, {4'hF, 30'h1B1B1B1B});
        chk("full_count", dct_count, 0);

        // Partial flush: 3,3,1 then flush with 2
        step(1, 2'd3, 0, 1); step(1, 2'd3, 0, 1); step(1, 2'd1, 0, 1);
        step(1, 2'd2, 1, 1);
        chk("partial_frame", frame_data, {4'h4, 30'h000000F6});

        // Flush on empty buffer
        step(1, 2'd0, 0, 1, 0);
        step(0, 2'd0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 2'd0, 0, 1);
            chk("empty_flush_no_frame", frame_valid, 0);
        end

        // Backpressure: two frames then 10 dropped atoms
        base = n_frames;
        for (int i = 0; i < 40; i++) step(1, 2'($urandom_range(0, 3)), 0, 0);
        chk("bp_count", dct_count, 15);
        chk("bp_overflow", overflow, 1);
        chk("bp_drops", drop_count, 10);
        drain("bp");
        chk("bp_frames", n_frames - base, 2);

        // Continuous stream
        base = n_frames;
        for (int i = 0; i < 300; i++) step(1, 2'($urandom_range(0, 3)), 0, 1);
        step(0, 2'd0, 0, 1);
        chk("stream_frames", n_frames - base, 20);
        chk("stream_drops", drop_count, 10);

        // Reset mid-fill with a frame pending
        for (int i = 0; i < 22; i++) step(1, 2'($urandom_range(0, 3)), 0, 0);
        chk("pre_reset_count", dct_count, 7);
        step(1, 2'd1, 0, 0, 0);
        chk("rst_frame_data", frame_data, 0);
        chk("rst_all", {frame_valid, dct_buffer, dct_count, overflow, drop_count}, 0);
        step(1, 2'd2, 0, 0);
        chk("post_reset_count", dct_count, 1);

        // Randomized mix
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
